// File: rtl/fetch_queue.sv
// Dual-issue fetch queue: circular buffer taking instruction pairs, handing out up to two per cycle.
// One-cycle latency; in_ready drops when fewer than two slots are free. FETCH_QUEUE_DEBUG_EN adds occupancy/high_water.
module fetch_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_address,
  input  logic [XLEN-1:0] in_instr_0,
  input  logic [XLEN-1:0] in_instr_1,
  output logic            out_valid_0,
  output logic            out_valid_1,
  output logic [XLEN-1:0] out_instr_0,
  output logic [XLEN-1:0] out_instr_1,
  output logic [XLEN-1:0] out_address_0,
  output logic [XLEN-1:0] out_address_1,
`ifdef FETCH_QUEUE_DEBUG_EN
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [$clog2(DEPTH):0] high_water,
`endif
  input  logic            plus_4,
  input  logic            plus_8
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] PUSH_LIMIT = CW'(DEPTH - 2);

  typedef struct packed {
    logic [XLEN-1:0] address;
    logic [XLEN-1:0] instr;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;

  logic [PW-1:0]   head_p1;
  logic [PW-1:0]   tail_p1;
  logic            push;
  logic [1:0]      pop_req;
  logic [CW-1:0]   pop;
  logic [CW-1:0]   count_next;

  assign head_p1 = head + PW'(1);
  assign tail_p1 = tail + PW'(1);

  // Ready looks only at registered count; a pop in this cycle does not free space early.
  assign in_ready = (count <= PUSH_LIMIT) && !flush && !reset;
  assign push     = in_valid && in_ready;

  always_comb begin
    pop_req = 2'd0;
    if (plus_8) begin
      pop_req = 2'd2;
    end else if (plus_4) begin
      pop_req = 2'd1;
    end
  end

  assign pop        = (CW'(pop_req) > count) ? count : CW'(pop_req);
  assign count_next = count + (push ? CW'(2) : CW'(0)) - pop;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + pop[PW-1:0];
      count <= count_next;
      if (push) begin
        tail <= tail + PW'(2);
      end
    end
  end

  // Storage is never cleared; count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail]    <= '{address: in_address,             instr: in_instr_0};
      mem[tail_p1] <= '{address: in_address + XLEN'(4),  instr: in_instr_1};
    end
  end

  assign out_valid_0   = (count >= CW'(1));
  assign out_valid_1   = (count >= CW'(2));
  assign out_instr_0   = mem[head].instr;
  assign out_address_0 = mem[head].address;
  assign out_instr_1   = mem[head_p1].instr;
  assign out_address_1 = mem[head_p1].address;

`ifdef FETCH_QUEUE_DEBUG_EN
  logic [CW-1:0] high_water_q;
  logic [CW-1:0] count_after;

  // Flush empties the queue but keeps the watermark; only reset clears it.
  assign count_after = flush ? '0 : count_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      high_water_q <= '0;
    end else if (count_after > high_water_q) begin
      high_water_q <= count_after;
    end
  end

  assign occupancy  = count;
  assign high_water = high_water_q;
`endif

endmodule
